// File: rtl/cpu_mc_pkg.sv
// Shared types and constants for the multi-cycle execute sequencer.
//
// Contents:
//   mc_state_e   - sequencer state encoding (IDLE, START, WAIT, WB, DRAIN)
//   MC_UNIT_*    - index assignment of the attached execute units
//   mc_unit_t    - wide unit index, used for range checks on issued indices
//   mc_is_busy() - states in which the sequencer always holds the pipeline
//
// Optional feature macro used by the design files: CPU_MC_TIMEOUT_EN.
package cpu_mc_pkg;

  typedef enum logic [2:0] {
    MC_IDLE  = 3'd0,
    MC_START = 3'd1,
    MC_WAIT  = 3'd2,
    MC_WB    = 3'd3,
    MC_DRAIN = 3'd4
  } mc_state_e;

  localparam int MC_UNIT_SHIFT  = 0;
  localparam int MC_UNIT_MULDIV = 1;

  localparam int MC_UNIT_IDX_W = 8;
  typedef logic [MC_UNIT_IDX_W-1:0] mc_unit_t;

  function automatic logic mc_is_busy(input mc_state_e s);
    return (s == MC_START) || (s == MC_WAIT) || (s == MC_DRAIN);
  endfunction

endpackage

// File: rtl/cpu_mc_watchdog.sv
// Hang watchdog for the multi-cycle sequencer. Only instantiated when
// CPU_MC_TIMEOUT_EN is defined.
//
// Ports:
//   clk_i      in  clock
//   rst_i      in  synchronous active-high reset
//   active_i   in  sequencer is in a waiting state (WAIT or DRAIN)
//   restart_i  in  re-arm the count (moving from WAIT into DRAIN)
//   expired_o  out count reached LIMIT-1 while active
//
// The count is held at zero whenever the sequencer is not waiting, so the
// first cycle of a WAIT/DRAIN episode always sees a count of zero.
module cpu_mc_watchdog
  import cpu_mc_pkg::*;
#(
  parameter int LIMIT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic restart_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT) + 1;

  logic [CW-1:0] cnt;

  assign expired_o = active_i && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || !active_i || restart_i) begin
      cnt <= '0;
    end else if (!expired_o) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cpu_mc_ctrl.sv
// Sequencer for multi-cycle execute units (shifter, mul/div) between
// decode/issue and writeback. Accepts one op at a time, pulses the selected
// unit's start, stalls the pipeline until the unit reports done, then holds
// the result until writeback consumes it. Flushes are honoured without
// aborting a unit: an in-flight unit is drained before a new op is accepted.
//
// Ports:
//   clk_i          in   clock
//   rst_i          in   synchronous active-high reset
//   issue_valid_i  in   decode presents a multi-cycle op
//   issue_unit_i   in   target unit index
//   issue_rd_i     in   destination register
//   issue_ready_o  out  op accepted this cycle when valid && ready
//   flush_i        in   kill in-flight op
//   unit_start_o   out  one-hot, single-cycle start pulse
//   unit_done_i    in   per-unit done (may be high while the unit is idle)
//   unit_res_i     in   per-unit result, unit k at [k*XLEN +: XLEN]
//   stall_o        out  hold upstream pipeline
//   wb_valid_o     out  result available
//   wb_rd_o        out  destination of held result
//   wb_data_o      out  held result
//   wb_ready_i     in   writeback consumes when valid && ready
//   err_o          out  held result is a watchdog timeout
//
// Optional feature: define CPU_MC_TIMEOUT_EN to add a hang watchdog that
// forces a zero result with err_o after TIMEOUT_CYCLES waiting cycles.
// Without it err_o stays 0 and WAIT/DRAIN wait indefinitely.
module cpu_mc_ctrl
  import cpu_mc_pkg::*;
#(
  parameter int N_UNITS        = 2,
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int UW            = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    issue_valid_i,
  input  logic [UW-1:0]           issue_unit_i,
  input  logic [4:0]              issue_rd_i,
  output logic                    issue_ready_o,
  input  logic                    flush_i,
  output logic [N_UNITS-1:0]      unit_start_o,
  input  logic [N_UNITS-1:0]      unit_done_i,
  input  logic [N_UNITS*XLEN-1:0] unit_res_i,
  output logic                    stall_o,
  output logic                    wb_valid_o,
  output logic [4:0]              wb_rd_o,
  output logic [XLEN-1:0]         wb_data_o,
  input  logic                    wb_ready_i,
  output logic                    err_o
);

  mc_state_e        state;
  logic [UW-1:0]    unit_q;
  logic             issue_in_range;
  logic [N_UNITS-1:0] start_vec;
  logic             done_sel;
  logic [XLEN-1:0]  res_sel;
  logic             wd_expired;

  assign issue_ready_o  = (state == MC_IDLE) && !flush_i;
  assign stall_o        = mc_is_busy(state) || ((state == MC_WB) && !wb_ready_i);
  assign issue_in_range = (mc_unit_t'(issue_unit_i) < mc_unit_t'(N_UNITS));

  // Decode the issued index into the start pulse; an out-of-range index
  // decodes to no unit at all.
  always_comb begin
    start_vec = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (issue_unit_i == UW'(k)) start_vec[k] = 1'b1;
    end
  end

  // Done/result of the latched unit only; other units' done lines are
  // ignored because they may be high while idle.
  always_comb begin
    done_sel = 1'b0;
    res_sel  = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (unit_q == UW'(k)) begin
        done_sel = unit_done_i[k];
        res_sel  = unit_res_i[k*XLEN +: XLEN];
      end
    end
  end

`ifdef CPU_MC_TIMEOUT_EN
  cpu_mc_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .active_i  ((state == MC_WAIT) || (state == MC_DRAIN)),
    .restart_i ((state == MC_WAIT) && flush_i),
    .expired_o (wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign wd_expired         = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= MC_IDLE;
      unit_q       <= '0;
      unit_start_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      err_o        <= 1'b0;
    end else begin
      unit_start_o <= '0;
      case (state)
        MC_IDLE: begin
          if (issue_valid_i && !flush_i) begin
            unit_q  <= issue_unit_i;
            wb_rd_o <= issue_rd_i;
            err_o   <= 1'b0;
            if (issue_in_range) begin
              unit_start_o <= start_vec;
              state        <= MC_START;
            end else begin
              // No unit to run: complete immediately with a zero result.
              wb_data_o  <= '0;
              wb_valid_o <= 1'b1;
              state      <= MC_WB;
            end
          end
        end

        // ---- start pulse is on the output this cycle ----
        MC_START: begin
          state <= flush_i ? MC_DRAIN : MC_WAIT;
        end

        // ---- waiting for the unit ----
        MC_WAIT: begin
          if (flush_i) begin
            // A unit cannot abort; if its done is already here nothing is
            // left to drain.
            state <= done_sel ? MC_IDLE : MC_DRAIN;
          end else if (done_sel) begin
            wb_data_o  <= res_sel;
            wb_valid_o <= 1'b1;
            state      <= MC_WB;
          end else if (wd_expired) begin
            wb_data_o  <= '0;
            err_o      <= 1'b1;
            wb_valid_o <= 1'b1;
            state      <= MC_WB;
          end
        end

        // ---- holding result for writeback ----
        MC_WB: begin
          if (flush_i || wb_ready_i) begin
            wb_valid_o <= 1'b0;
            err_o      <= 1'b0;
            state      <= MC_IDLE;
          end
        end

        // ---- discarding a flushed op ----
        MC_DRAIN: begin
          if (done_sel || wd_expired) state <= MC_IDLE;
        end

        default: state <= MC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// Self-checking bench for cpu_mc_ctrl. Behavioural execute units (shifter,
// mul, adder) respond to the start pulses; expected timing and data come
// from per-op latency arithmetic. Unit results read back inverted while a
// unit is busy so an early capture shows up as wrong data.
module tb_cpu_mc_ctrl;
  import cpu_mc_pkg::*;

  localparam int N_UNITS = 3;
  localparam int XLEN    = 32;
  localparam int TMO     = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    issue_valid = 1'b0;
  logic [1:0]              issue_unit = '0;
  logic [4:0]              issue_rd = '0;
  logic                    issue_ready;
  logic                    flush = 1'b0;
  logic [N_UNITS-1:0]      unit_start;
  logic [N_UNITS-1:0]      unit_done;
  logic [N_UNITS*XLEN-1:0] unit_res;
  logic                    stall;
  logic                    wb_valid;
  logic [4:0]              wb_rd;
  logic [XLEN-1:0]         wb_data;
  logic                    wb_ready = 1'b0;
  logic                    err;

  int n_checks = 0;
  int n_errors = 0;
  int wb_count = 0;

  logic [31:0]        op_a = '0;
  logic [31:0]        op_b = '0;
  int                 lat_md = 0;
  logic [N_UNITS-1:0] stuck = '0;
  int unsigned        rem [N_UNITS];
  logic [31:0]        ures [N_UNITS];

  always #5 clk = ~clk;

  cpu_mc_ctrl #(
    .N_UNITS(N_UNITS), .XLEN(XLEN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_unit_i(issue_unit),
    .issue_rd_i(issue_rd), .issue_ready_o(issue_ready), .flush_i(flush),
    .unit_start_o(unit_start), .unit_done_i(unit_done), .unit_res_i(unit_res),
    .stall_o(stall), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .wb_ready_i(wb_ready), .err_o(err)
  );

  function automatic int unit_lat(input int u, input logic [31:0] b);
    case (u)
      MC_UNIT_SHIFT:  return int'(b[4:0]);
      MC_UNIT_MULDIV: return lat_md;
      default:        return 2;
    endcase
  endfunction

  function automatic logic [31:0] unit_func(input int u, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (u)
      MC_UNIT_SHIFT:  return sa >>> b[4:0];
      MC_UNIT_MULDIV: return a * b;
      default:        return a + b;
    endcase
  endfunction

  // Execute-unit stand-ins: latch on start, count down busy cycles.
  always @(posedge clk) begin
    for (int k = 0; k < N_UNITS; k++) begin
      if (rst) rem[k] <= 0;
      else if (unit_start[k]) begin
        rem[k]  <= unit_lat(k, op_b);
        ures[k] <= unit_func(k, op_a, op_b);
      end else if (rem[k] != 0) rem[k] <= rem[k] - 1;
    end
  end

  always_comb begin
    unit_done = '0;
    unit_res  = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      unit_done[k] = (rem[k] == 0) && !stuck[k];
      unit_res[k*XLEN +: XLEN] = unit_done[k] ? ures[k] : ~ures[k];
    end
  end

  always @(posedge clk) begin
    if (!rst && wb_valid && wb_ready && !flush) wb_count <= wb_count + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic accept(input int unit, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    cycle();
    op_a = a; op_b = b;
    issue_valid = 1'b1; issue_unit = unit[1:0]; issue_rd = rd;
    flush = 1'b0; wb_ready = 1'b0;
    settle();
    chk("idle_ready", issue_ready, 1);
    chk("idle_stall", stall, 0);
    chk("idle_wbv", wb_valid, 0);
  endtask

  task automatic run_op(input int unit, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold,
                        output int wb_rel, output logic [31:0] data_seen);
    bit inr;
    int exp_wb, held, wbc0;
    bit done;
    logic [31:0] exp_d;
    inr    = (unit < N_UNITS);
    exp_wb = inr ? 3 + unit_lat(unit, b) : 1;
    exp_d  = inr ? unit_func(unit, a, b) : 32'h0;
    held = 0; done = 0; wb_rel = -1; data_seen = '0;
    wbc0 = wb_count;
    accept(unit, a, b, rd);
    for (int rel = 1; rel < 100 && !done; rel++) begin
      cycle();
      wb_ready    = (rel >= exp_wb) && (held >= hold);
      issue_valid = wb_ready ? 1'b0 : 1'($urandom);
      issue_unit  = 2'($urandom);
      issue_rd    = 5'($urandom);
      settle();
      chk("start", unit_start, (rel == 1 && inr) ? (64'd1 << unit) : 64'd0);
      if (wb_valid && wb_rel < 0) wb_rel = rel;
      if (rel < exp_wb) begin
        chk("busy_wbv", wb_valid, 0);
        chk("busy_stall", stall, 1);
        chk("busy_ready", issue_ready, 0);
      end else begin
        chk("wbv", wb_valid, 1);
        chk("wb_data", wb_data, exp_d);
        chk("wb_rd", wb_rd, rd);
        chk("wb_err", err, 0);
        chk("wb_stall", stall, !wb_ready);
        data_seen = wb_data;
        if (wb_ready) done = 1;
        held++;
      end
    end
    if (!done) chk("op_timeout", 0, 1);
    cycle();
    issue_valid = 1'b0; wb_ready = 1'b0;
    settle();
    chk("wb_count", wb_count - wbc0, 1);
    chk("post_wbv", wb_valid, 0);
    chk("post_ready", issue_ready, 1);
  endtask

  task automatic flush_op(input int unit, input logic [31:0] a, input logic [31:0] b, input int frel);
    int k, idle_rel, wbc0;
    bit in_wb;
    k = unit_lat(unit, b);
    idle_rel = (3 + k > frel + 1) ? 3 + k : frel + 1;
    wbc0 = wb_count;
    accept(unit, a, b, 5'($urandom));
    for (int rel = 1; rel <= idle_rel; rel++) begin
      cycle();
      in_wb       = (rel >= 3 + k) && (rel <= frel);
      flush       = (rel == frel);
      wb_ready    = (rel < 3 + k) ? 1'($urandom) : (rel == frel);
      issue_valid = (rel == idle_rel) ? 1'b0 : 1'($urandom);
      settle();
      chk("f_start", unit_start, (rel == 1) ? (64'd1 << unit) : 64'd0);
      if (rel < idle_rel) begin
        chk("f_wbv", wb_valid, in_wb);
        if (in_wb) chk("f_data", wb_data, unit_func(unit, a, b));
        chk("f_stall", stall, in_wb ? !wb_ready : 1'b1);
        chk("f_ready", issue_ready, 0);
      end else begin
        chk("f_idle_ready", issue_ready, 1);
        chk("f_idle_stall", stall, 0);
        chk("f_idle_wbv", wb_valid, 0);
      end
    end
    flush = 1'b0; wb_ready = 1'b0;
    chk("f_no_wb", wb_count - wbc0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start"}, unit_start, 0);
    chk({tag, "_wbv"}, wb_valid, 0);
    chk({tag, "_rd"}, wb_rd, 0);
    chk({tag, "_data"}, wb_data, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_ready"}, issue_ready, 1);
  endtask

  initial begin
    int rel;
    logic [31:0] d;
    int u;

    // Reset with noisy inputs.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      issue_valid = 1'($urandom); issue_unit = 2'($urandom); wb_ready = 1'($urandom);
    end
    issue_valid = 1'b0; wb_ready = 1'b0;
    cycle();
    rst = 1'b0;
    settle();
    check_reset_outputs("reset");

    // Arithmetic shift of the sign bit by 4.
    run_op(MC_UNIT_SHIFT, 32'h8000_0000, 32'd4, 5'd7, 0, rel, d);
    chk("sra_wb_cycle", rel, 7);
    chk("sra_data", d, 32'hF800_0000);

    // Shift by zero with writeback back-pressure.
    run_op(MC_UNIT_SHIFT, 32'h0000_1234, 32'd0, 5'd9, 3, rel, d);
    chk("sh0_wb_cycle", rel, 3);
    chk("sh0_data", d, 32'h0000_1234);

    // Flush during WAIT of a 31-bit shift: drain until done at cycle 33.
    flush_op(MC_UNIT_SHIFT, 32'hDEAD_BEEF, 32'd31, 3);

    // Flush together with wb_valid && wb_ready.
    flush_op(2, 32'd5, 32'd6, 6);

    // Flush in IDLE blocks the accept.
    cycle();
    issue_valid = 1'b1; issue_unit = 2'd0; flush = 1'b1;
    settle();
    chk("idle_flush_ready", issue_ready, 0);
    cycle();
    issue_valid = 1'b0; flush = 1'b0;
    settle();
    chk("idle_flush_start", unit_start, 0);
    chk("idle_flush_stall", stall, 0);
    chk("idle_flush_ready2", issue_ready, 1);

    // Out-of-range unit index.
    run_op(3, 32'h1111_2222, 32'h3, 5'd17, 1, rel, d);
    chk("oor_wb_cycle", rel, 1);
    chk("oor_data", d, 32'h0);

    // Reset while waiting on a long shift, then a normal op.
    accept(MC_UNIT_SHIFT, 32'hCAFE_0000, 32'd20, 5'd3);
    for (int r = 1; r <= 5; r++) begin
      cycle();
      issue_valid = 1'b0;
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    settle();
    check_reset_outputs("midrst");
    lat_md = 2;
    run_op(MC_UNIT_MULDIV, 32'd7, 32'd9, 5'd21, 0, rel, d);
    chk("after_rst_data", d, 32'd63);

    // Unit whose done never rises.
    stuck[MC_UNIT_MULDIV] = 1'b1;
    lat_md = 0;
`ifdef CPU_MC_TIMEOUT_EN
    accept(MC_UNIT_MULDIV, 32'd3, 32'd4, 5'd11);
    rel = -1;
    for (int r = 1; r <= 40 && rel < 0; r++) begin
      cycle();
      issue_valid = 1'b0; wb_ready = 1'b0;
      settle();
      if (wb_valid) rel = r;
      else chk("to_stall", stall, 1);
    end
    chk("to_wb_cycle", rel, 10);
    chk("to_err", err, 1);
    chk("to_data", wb_data, 0);
    chk("to_rd", wb_rd, 11);
    cycle();
    wb_ready = 1'b1;
    settle();
    chk("to_err_held", err, 1);
    chk("to_wbv_held", wb_valid, 1);
    cycle();
    wb_ready = 1'b0;
    settle();
    chk("to_err_clr", err, 0);
    chk("to_idle", issue_ready, 1);
    accept(MC_UNIT_MULDIV, 32'd3, 32'd4, 5'd12);
    rel = -1;
    for (int r = 1; r <= 40 && rel < 0; r++) begin
      cycle();
      issue_valid = 1'b0;
      flush = (r == 3);
      settle();
      if (issue_ready) rel = r;
      else chk("to_drain_wbv", wb_valid, 0);
    end
    flush = 1'b0;
    chk("to_drain_cycle", rel, 12);
    stuck = '0;
`else
    accept(MC_UNIT_MULDIV, 32'd3, 32'd4, 5'd11);
    for (int r = 1; r <= 30; r++) begin
      cycle();
      issue_valid = 1'b0; wb_ready = 1'($urandom);
      settle();
      chk("hang_stall", stall, 1);
      chk("hang_wbv", wb_valid, 0);
      chk("hang_err", err, 0);
    end
    wb_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    stuck = '0;
    settle();
    check_reset_outputs("hang_rst");
`endif

    // Randomised completed ops.
    for (int i = 0; i < 30; i++) begin
      u = $urandom_range(0, 3);
      lat_md = $urandom_range(0, 6);
      run_op(u, $urandom, (u == MC_UNIT_SHIFT) ? 32'($urandom_range(0, 31)) : $urandom,
             5'($urandom), $urandom_range(0, 3), rel, d);
    end

    // Randomised flushed ops.
    for (int i = 0; i < 20; i++) begin
      int k, b;
      u = $urandom_range(0, 2);
      lat_md = $urandom_range(0, 6);
      b = (u == MC_UNIT_SHIFT) ? $urandom_range(0, 12) : $urandom;
      k = unit_lat(u, b);
      flush_op(u, $urandom, b, $urandom_range(1, k + 5));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
